// File: rtl/key_sw_io_pkg.sv
// Shared constants and address decode for the KEY/SW memory-mapped input responder.
package key_sw_io_pkg;

    // Register addresses on the processor data bus
    localparam logic [31:0] ADDR_KEY   = 32'hF0000010;
    localparam logic [31:0] ADDR_SW    = 32'hF0000014;
    localparam logic [31:0] ADDR_KSTAT = 32'hF0000110;
    localparam logic [31:0] ADDR_SSTAT = 32'hF0000114;
    localparam logic [31:0] ADDR_CTRL  = 32'hF0000120;

    // Board input widths
    localparam int NUM_KEYS = 4;
    localparam int NUM_SW   = 10;
    localparam int NUM_IN   = NUM_KEYS + NUM_SW;

    // KSTAT fields
    localparam int KFLAG_LSB = 0;
    localparam int KFLAG_MSB = 3;
    localparam int KOVR_BIT  = 4;

    // SSTAT fields
    localparam int SFLAG_BIT = 0;
    localparam int SOVR_BIT  = 1;

    // CTRL fields
    localparam int KIE_LSB = 0;
    localparam int KIE_MSB = 3;
    localparam int SIE_BIT = 4;

    // Default debounce timing: one sample every TICK_DIV clocks, SAMPLES agreeing samples to accept
    localparam int DEFAULT_TICK_DIV = 50000;
    localparam int DEFAULT_SAMPLES  = 8;

    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_KEY,
        SEL_SW,
        SEL_KSTAT,
        SEL_SSTAT,
        SEL_CTRL
    } regSel_t;

    // Maps a bus address onto the register it selects (SEL_NONE when unmapped)
    function automatic regSel_t decodeAddr(input logic [31:0] a);
        case (a)
            ADDR_KEY:   return SEL_KEY;
            ADDR_SW:    return SEL_SW;
            ADDR_KSTAT: return SEL_KSTAT;
            ADDR_SSTAT: return SEL_SSTAT;
            ADDR_CTRL:  return SEL_CTRL;
            default:    return SEL_NONE;
        endcase
    endfunction

endpackage

// File: rtl/key_sw_io_debounce.sv
// Single-bit debouncer: accepts a new level only after SAMPLES consecutive ticks disagree with it.
module io_debounce #(
    parameter int SAMPLES = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic tick,
    input  logic sample,
    output logic st,
    output logic rise,
    output logic fall
);

    localparam int CW = (SAMPLES > 1) ? $clog2(SAMPLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(SAMPLES - 1);

    logic          r_st;
    logic [CW-1:0] r_cnt;
    logic          w_accept;

    // The level flips on the tick that completes the run of disagreeing samples
    assign w_accept = tick && (sample != r_st) && (r_cnt == CNT_LAST);
    assign st       = r_st;
    assign rise     = w_accept && sample;
    assign fall     = w_accept && !sample;

    // Count disagreeing ticks; any agreeing tick restarts the run
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_st  <= 1'b0;
            r_cnt <= '0;
        end else if (tick) begin
            if (sample == r_st) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
                r_st  <= sample;
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/key_sw_io.sv
// Memory-mapped KEY/SW responder: synchronise, debounce, sticky event flags and level interrupt.
module key_sw_io
    import key_sw_io_pkg::*;
#(
    parameter int TICK_DIV = DEFAULT_TICK_DIV,
    parameter int SAMPLES  = DEFAULT_SAMPLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic        wrEn,
    input  logic [31:0] wrData,
    output logic [31:0] rdData,
    output logic        hit,
    input  logic [3:0]  KEY,
    input  logic [9:0]  SW,
    output logic        irq
);

    localparam int TCW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TCW-1:0] TICK_LAST = TCW'(TICK_DIV - 1);

    logic [NUM_KEYS-1:0] r_keySync1, r_keySync2;
    logic [NUM_SW-1:0]   r_swSync1, r_swSync2;
    logic [TCW-1:0]      r_tickCnt;
    logic                w_tick;

    logic [NUM_IN-1:0]   w_sample, w_st, w_rise, w_fall;
    logic [NUM_KEYS-1:0] w_keySt, w_keyPress;
    logic [NUM_SW-1:0]   w_swSt;
    logic                w_swChange;

    logic [KFLAG_MSB:KFLAG_LSB] r_kflag;
    logic                       r_kovr;
    logic                       r_sflag, r_sovr;
    logic [KIE_MSB:KIE_LSB]     r_kie;
    logic                       r_sie;
    logic                       r_irq;

    regSel_t             w_sel;
    logic                w_wrKstat, w_wrSstat, w_wrCtrl;
    logic [KOVR_BIT:0]   w_kClr;
    logic [SOVR_BIT:0]   w_sClr;

    // Key releases and the upper write-data bits have no function here
    logic w_unusedBits;
    assign w_unusedBits = ^{w_fall[NUM_KEYS-1:0], wrData[31:SIE_BIT+1]};

    // Two-flop synchronisers; keys are inverted first so 1 means pressed
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_keySync1 <= '0;
            r_keySync2 <= '0;
            r_swSync1  <= '0;
            r_swSync2  <= '0;
        end else begin
            r_keySync1 <= ~KEY;
            r_keySync2 <= r_keySync1;
            r_swSync1  <= SW;
            r_swSync2  <= r_swSync1;
        end
    end

    // Free-running divider producing the one-cycle debounce sample tick
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)      r_tickCnt <= '0;
        else if (w_tick) r_tickCnt <= '0;
        else             r_tickCnt <= r_tickCnt + 1'b1;
    end

    assign w_tick   = (r_tickCnt == TICK_LAST);
    assign w_sample = {r_swSync2, r_keySync2};

    for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_deb
        io_debounce #(.SAMPLES(SAMPLES)) u_deb (
            .clk    (clk),
            .reset  (reset),
            .tick   (w_tick),
            .sample (w_sample[gi]),
            .st     (w_st[gi]),
            .rise   (w_rise[gi]),
            .fall   (w_fall[gi])
        );
    end

    assign w_keySt    = w_st[NUM_KEYS-1:0];
    assign w_swSt     = w_st[NUM_IN-1:NUM_KEYS];
    assign w_keyPress = w_rise[NUM_KEYS-1:0];
    assign w_swChange = |(w_rise[NUM_IN-1:NUM_KEYS] | w_fall[NUM_IN-1:NUM_KEYS]);

    assign w_sel     = decodeAddr(addr);
    assign hit       = (w_sel != SEL_NONE);
    assign w_wrKstat = wrEn && (w_sel == SEL_KSTAT);
    assign w_wrSstat = wrEn && (w_sel == SEL_SSTAT);
    assign w_wrCtrl  = wrEn && (w_sel == SEL_CTRL);
    assign w_kClr    = w_wrKstat ? wrData[KOVR_BIT:0] : '0;
    assign w_sClr    = w_wrSstat ? wrData[SOVR_BIT:0] : '0;

    // Sticky flags: a new event beats a simultaneous clear, and that collision is not an overrun
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_kflag <= '0;
            r_kovr  <= 1'b0;
            r_sflag <= 1'b0;
            r_sovr  <= 1'b0;
        end else begin
            r_kflag <= (r_kflag & ~w_kClr[KFLAG_MSB:KFLAG_LSB]) | w_keyPress;
            r_kovr  <= (r_kovr & ~w_kClr[KOVR_BIT])
                     | (|(w_keyPress & r_kflag & ~w_kClr[KFLAG_MSB:KFLAG_LSB]));
            r_sflag <= (r_sflag & ~w_sClr[SFLAG_BIT]) | w_swChange;
            r_sovr  <= (r_sovr & ~w_sClr[SOVR_BIT])
                     | (w_swChange & r_sflag & ~w_sClr[SFLAG_BIT]);
        end
    end

    // Interrupt enables, loaded whole on a CTRL write
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_kie <= '0;
            r_sie <= 1'b0;
        end else if (w_wrCtrl) begin
            r_kie <= wrData[KIE_MSB:KIE_LSB];
            r_sie <= wrData[SIE_BIT];
        end
    end

    // Registered interrupt, one cycle behind the flags and enables
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_irq <= 1'b0;
        else        r_irq <= (|(r_kflag & r_kie)) | (r_sflag & r_sie);
    end

    assign irq = r_irq;

    // Read mux; reads have no side effects and unmapped addresses return zero
    always_comb begin
        rdData = '0;
        case (w_sel)
            SEL_KEY:   rdData[NUM_KEYS-1:0] = w_keySt;
            SEL_SW:    rdData[NUM_SW-1:0]   = w_swSt;
            SEL_KSTAT: begin
                rdData[KFLAG_MSB:KFLAG_LSB] = r_kflag;
                rdData[KOVR_BIT]            = r_kovr;
            end
            SEL_SSTAT: begin
                rdData[SFLAG_BIT] = r_sflag;
                rdData[SOVR_BIT]  = r_sovr;
            end
            SEL_CTRL: begin
                rdData[KIE_MSB:KIE_LSB] = r_kie;
                rdData[SIE_BIT]         = r_sie;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_key_sw_io.sv
// Self-checking bench for key_sw_io with a short debounce (TICK_DIV=4, SAMPLES=3).
`timescale 1ns/1ps
module tb_key_sw_io;

    localparam int TD = 4;
    localparam int NS = 3;
    localparam logic [31:0] A_KEY   = 32'hF0000010;
    localparam logic [31:0] A_SW    = 32'hF0000014;
    localparam logic [31:0] A_KSTAT = 32'hF0000110;
    localparam logic [31:0] A_SSTAT = 32'hF0000114;
    localparam logic [31:0] A_CTRL  = 32'hF0000120;
    localparam logic [31:0] A_NONE  = 32'hF0000018;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] addr = '0;
    logic        wrEn = 1'b0;
    logic [31:0] wrData = '0;
    logic [31:0] rdData;
    logic        hit;
    logic [3:0]  KEY = 4'hF;
    logic [9:0]  SW = '0;
    logic        irq;

    int checks = 0;
    int fails  = 0;

    key_sw_io #(.TICK_DIV(TD), .SAMPLES(NS)) dut (
        .clk    (clk),
        .reset  (reset),
        .addr   (addr),
        .wrEn   (wrEn),
        .wrData (wrData),
        .rdData (rdData),
        .hit    (hit),
        .KEY    (KEY),
        .SW     (SW),
        .irq    (irq)
    );

    always #5 clk = ~clk;

    // Reference model: pins seen two edges late, sampled every TD edges after reset,
    // a level is accepted once NS consecutive samples disagree with it
    logic [13:0] m_delay[2];
    logic [13:0] m_st;
    int          m_run[14];
    int          m_cyc;
    logic [3:0]  m_kflag, m_kie;
    logic        m_kovr, m_sflag, m_sovr, m_sie, m_irq;
    logic [13:0] smp;
    logic [3:0]  press;
    logic        swChg, isTick;
    logic [4:0]  kc;
    logic [1:0]  sc;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_delay[0] = '0; m_delay[1] = '0; m_st = '0; m_cyc = 0;
            for (int i = 0; i < 14; i++) m_run[i] = 0;
            m_kflag = '0; m_kie = '0; m_kovr = 0; m_sflag = 0; m_sovr = 0; m_sie = 0; m_irq = 0;
        end else begin
            smp = m_delay[1];
            m_delay[1] = m_delay[0];
            m_delay[0] = {SW, ~KEY};
            isTick = ((m_cyc % TD) == TD - 1);
            m_cyc++;
            press = '0;
            swChg = 1'b0;
            if (isTick) begin
                for (int i = 0; i < 14; i++) begin
                    if (smp[i] != m_st[i]) begin
                        m_run[i]++;
                        if (m_run[i] == NS) begin
                            m_st[i] = smp[i];
                            m_run[i] = 0;
                            if (i < 4) begin
                                if (smp[i]) press[i[1:0]] = 1'b1;
                            end else begin
                                swChg = 1'b1;
                            end
                        end
                    end else begin
                        m_run[i] = 0;
                    end
                end
            end
            kc = (wrEn && addr == A_KSTAT) ? wrData[4:0] : 5'b0;
            sc = (wrEn && addr == A_SSTAT) ? wrData[1:0] : 2'b0;
            m_irq   = (|(m_kflag & m_kie)) | (m_sflag & m_sie);
            m_kovr  = (m_kovr && !kc[4]) || (|(press & m_kflag & ~kc[3:0]));
            m_kflag = (m_kflag & ~kc[3:0]) | press;
            m_sovr  = (m_sovr && !sc[1]) || (swChg && m_sflag && !sc[0]);
            m_sflag = (m_sflag && !sc[0]) || swChg;
            if (wrEn && addr == A_CTRL) begin
                m_kie = wrData[3:0];
                m_sie = wrData[4];
            end
        end
    end

    function automatic logic [31:0] mRead(input logic [31:0] a);
        case (a)
            A_KEY:   return {28'b0, m_st[3:0]};
            A_SW:    return {22'b0, m_st[13:4]};
            A_KSTAT: return {27'b0, m_kovr, m_kflag};
            A_SSTAT: return {30'b0, m_sovr, m_sflag};
            A_CTRL:  return {27'b0, m_sie, m_kie};
            default: return 32'b0;
        endcase
    endfunction

    function automatic logic mHit(input logic [31:0] a);
        return (a == A_KEY) || (a == A_SW) || (a == A_KSTAT) || (a == A_SSTAT) || (a == A_CTRL);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Every cycle, shortly after the edge, the DUT must agree with the model
    always @(posedge clk) begin
        #2;
        checkOutput("model rdData", rdData, mRead(addr));
        checkOutput("model hit", {31'b0, hit}, {31'b0, mHit(addr)});
        checkOutput("model irq", {31'b0, irq}, {31'b0, m_irq});
    end

    task automatic applyStimulus(input logic [31:0] a, input logic we, input logic [31:0] d);
        @(negedge clk);
        addr = a;
        wrEn = we;
        wrData = d;
    endtask

    task automatic busWrite(input logic [31:0] a, input logic [31:0] d);
        applyStimulus(a, 1'b1, d);
        applyStimulus(a, 1'b0, 32'b0);
    endtask

    task automatic readCheck(input string name, input logic [31:0] a, input logic [31:0] exp);
        applyStimulus(a, 1'b0, 32'b0);
        #1;
        checkOutput(name, rdData, exp);
    endtask

    // Polls a register after each edge for up to maxN edges; call right after driving pins
    task automatic waitRead(input string name, input logic [31:0] a, input logic [31:0] exp, input int maxN);
        int n;
        addr = a;
        wrEn = 1'b0;
        n = 0;
        #1;
        while (rdData !== exp && n < maxN) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput(name, rdData, exp);
    endtask

    // Index of the edge carrying the k-th sample tick at or after edge e
    function automatic int nthTick(input int e, input int k);
        int nt = 0;
        for (int x = e; x < e + 64; x++) begin
            if ((x % TD) == TD - 1) begin
                nt++;
                if (nt == k) return x;
            end
        end
        return e;
    endfunction

    typedef struct {
        logic [31:0] addr;
        logic        wrEn;
        logic [31:0] wrData;
        logic [31:0] expRd;
        logic        expHit;
    } vec_t;

    vec_t        vecs[$];
    logic [31:0] addrs[6];
    int          e1, eTarget, n;

    initial begin
        addrs = '{A_KEY, A_SW, A_KSTAT, A_SSTAT, A_CTRL, A_NONE};

        // Reads reflect the value before any write on the same cycle
        vecs.push_back('{A_KEY,        1'b0, 32'h0,        32'h0,  1'b1});
        vecs.push_back('{A_SW,         1'b0, 32'h0,        32'h0,  1'b1});
        vecs.push_back('{A_KSTAT,      1'b0, 32'h0,        32'h0,  1'b1});
        vecs.push_back('{A_SSTAT,      1'b0, 32'h0,        32'h0,  1'b1});
        vecs.push_back('{A_CTRL,       1'b0, 32'h0,        32'h0,  1'b1});
        vecs.push_back('{A_NONE,       1'b0, 32'h0,        32'h0,  1'b0});
        vecs.push_back('{32'hF0000111, 1'b0, 32'h0,        32'h0,  1'b0});
        vecs.push_back('{A_CTRL,       1'b1, 32'h0000001F, 32'h0,  1'b1});
        vecs.push_back('{A_CTRL,       1'b0, 32'h0,        32'h1F, 1'b1});
        vecs.push_back('{A_CTRL,       1'b1, 32'hFFFFFFEA, 32'h1F, 1'b1});
        vecs.push_back('{A_CTRL,       1'b0, 32'h0,        32'h0A, 1'b1});
        vecs.push_back('{A_KEY,        1'b1, 32'hF,        32'h0,  1'b1});
        vecs.push_back('{A_NONE,       1'b1, 32'h1F,       32'h0,  1'b0});
        vecs.push_back('{A_CTRL,       1'b1, 32'h0,        32'h0A, 1'b1});
        vecs.push_back('{A_CTRL,       1'b0, 32'h0,        32'h0,  1'b1});

        repeat (3) @(negedge clk);
        reset = 1'b1;

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].addr, vecs[i].wrEn, vecs[i].wrData);
            #1;
            checkOutput($sformatf("vec%0d rdData", i), rdData, vecs[i].expRd);
            checkOutput($sformatf("vec%0d hit", i), {31'b0, hit}, {31'b0, vecs[i].expHit});
        end

        // Random bus traffic and slowly changing pins, checked against the model every cycle
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            addr = addrs[$urandom_range(0, 5)];
            wrEn = ($urandom_range(0, 7) == 0);
            wrData = $urandom;
            if ($urandom_range(0, 15) == 0) KEY = 4'($urandom);
            if ($urandom_range(0, 15) == 0) SW = SW ^ (10'b1 << $urandom_range(0, 9));
        end
        applyStimulus(A_KEY, 1'b0, 32'b0);
        KEY = 4'hF;
        SW = '0;
        repeat (30) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;

        // Press and release
        @(negedge clk);
        KEY = 4'b1110;
        waitRead("press KEY reg", A_KEY, 32'h1, 14);
        readCheck("press kflag", A_KSTAT, 32'h01);
        @(negedge clk);
        KEY = 4'hF;
        waitRead("release KEY reg", A_KEY, 32'h0, 14);
        readCheck("release kflag held", A_KSTAT, 32'h01);

        busWrite(A_KSTAT, 32'h01);
        readCheck("w1c KSTAT", A_KSTAT, 32'h0);

        // Short glitch must not be accepted
        @(negedge clk);
        KEY = 4'b1101;
        repeat (6) @(negedge clk);
        KEY = 4'hF;
        repeat (20) @(negedge clk);
        readCheck("bounce KEY reg", A_KEY, 32'h0);
        readCheck("bounce KSTAT", A_KSTAT, 32'h0);

        // Clear lands on the very edge a new press is accepted: set wins, no overrun
        @(negedge clk);
        KEY = 4'b1110;
        e1 = m_cyc;
        eTarget = nthTick(e1 + 2, NS);
        for (int k = 0; k < 40 && m_cyc != eTarget; k++) @(negedge clk);
        addr = A_KSTAT;
        wrEn = 1'b1;
        wrData = 32'h01;
        @(negedge clk);
        wrEn = 1'b0;
        wrData = 32'h0;
        #1;
        checkOutput("collision KSTAT", rdData, 32'h01);

        // Key overrun
        @(negedge clk);
        KEY = 4'hF;
        repeat (20) @(negedge clk);
        busWrite(A_KSTAT, 32'h1F);
        KEY = 4'b1011;
        repeat (20) @(negedge clk);
        KEY = 4'hF;
        repeat (20) @(negedge clk);
        KEY = 4'b1011;
        repeat (20) @(negedge clk);
        readCheck("key overrun", A_KSTAT, 32'h14);
        KEY = 4'hF;
        repeat (20) @(negedge clk);

        // Switch overrun
        busWrite(A_SSTAT, 32'h3);
        SW = 10'h001;
        repeat (20) @(negedge clk);
        SW = 10'h000;
        repeat (20) @(negedge clk);
        readCheck("sw overrun", A_SSTAT, 32'h3);
        busWrite(A_SSTAT, 32'h3);
        readCheck("SSTAT clear", A_SSTAT, 32'h0);

        // Switch interrupt follows sflag by one cycle, and drops one cycle after the clear
        busWrite(A_CTRL, 32'h10);
        @(negedge clk);
        SW = 10'h200;
        waitRead("sflag set", A_SSTAT, 32'h1, 14);
        checkOutput("irq lag", {31'b0, irq}, 32'h0);
        @(posedge clk);
        #1;
        checkOutput("irq assert", {31'b0, irq}, 32'h1);
        @(negedge clk);
        addr = A_SSTAT;
        wrEn = 1'b1;
        wrData = 32'h1;
        @(posedge clk);
        #1;
        checkOutput("sflag w1c", rdData, 32'h0);
        checkOutput("irq hold", {31'b0, irq}, 32'h1);
        @(negedge clk);
        wrEn = 1'b0;
        wrData = 32'h0;
        @(posedge clk);
        #1;
        checkOutput("irq deassert", {31'b0, irq}, 32'h0);

        // Reset in the middle of a debounce with a flag pending
        @(negedge clk);
        KEY = 4'b1110;
        repeat (20) @(negedge clk);
        busWrite(A_CTRL, 32'h1F);
        repeat (2) @(negedge clk);
        checkOutput("irq before reset", {31'b0, irq}, 32'h1);
        KEY = 4'b1100;
        e1 = m_cyc;
        eTarget = nthTick(e1 + 2, 2) + 1;
        for (int k = 0; k < 40 && m_cyc != eTarget; k++) @(negedge clk);
        reset = 1'b0;
        #0.5;
        checkOutput("reset irq", {31'b0, irq}, 32'h0);
        for (int r = 0; r < 5; r++) begin
            addr = addrs[r];
            #0.5;
            checkOutput($sformatf("reset read %0d", r), rdData, 32'h0);
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        waitRead("held key after reset", A_KSTAT, 32'h03, 14);
        readCheck("held KEY reg", A_KEY, 32'h3);

        applyStimulus(A_NONE, 1'b0, 32'b0);
        repeat (4) @(negedge clk);
        $display("[TB] %0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
